// File: rtl/seq_alu.sv
// Registered, handshaked ALU with NZCV flags and an iterative shift-add multiplier.
// Single-cycle ops retire one per cycle; MUL holds off the input side for BITS cycles.
module seq_alu #(
  parameter int BITS   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] src_a,
  input  logic [BITS-1:0] src_b,
  input  logic [3:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] alu_result,
  output logic [3:0]      alu_flags,
  output logic            busy
);
  localparam int SHAMT = $clog2(BITS);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_XOR = 4'b0100, OP_SLL = 4'b0101, OP_SRL = 4'b0110, OP_SRA = 4'b0111,
    OP_MUL = 4'b1000, OP_SLT = 4'b1001
  } op_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic [BITS-1:0]   mcand_q, mcand_d;
  logic [BITS-1:0]   mplier_q, mplier_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [SHAMT-1:0]  cnt_q, cnt_d;

  logic [BITS:0]     add_sum, sub_sum;
  logic [SHAMT-1:0]  amt;
  logic [BITS-1:0]   alu_res, mul_sum;
  logic              alu_c, alu_v, illegal;
  logic [3:0]        alu_flg;
  logic              is_mul, accept, mul_last;

  // Single-cycle datapath
  always_comb begin
    amt     = src_b[SHAMT-1:0];
    add_sum = {1'b0, src_a} + {1'b0, src_b};
    sub_sum = {1'b0, src_a} + {1'b0, ~src_b} + (BITS+1)'(1);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = add_sum[BITS-1:0];
        alu_c   = add_sum[BITS];
        alu_v   = (src_a[BITS-1] == src_b[BITS-1]) && (add_sum[BITS-1] != src_a[BITS-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[BITS-1:0];
        alu_c   = sub_sum[BITS];
        alu_v   = (src_a[BITS-1] != src_b[BITS-1]) && (sub_sum[BITS-1] != src_a[BITS-1]);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLL:  alu_res = src_a << amt;
      OP_SRL:  alu_res = src_a >> amt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> amt);
      OP_SLT:  alu_res = {{(BITS-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_MUL:  illegal = !MUL_EN;
      default: illegal = 1'b1;
    endcase
    alu_flg = illegal ? 4'b0001
                      : {alu_res == '0, alu_res[BITS-1], alu_c, alu_v};
  end

  always_comb begin
    in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    busy     = (state_q == S_MUL);
  end

  assign is_mul   = MUL_EN && (alu_op == OP_MUL);
  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt_q == SHAMT'(BITS-1));
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_last)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The final iteration writes the product straight into the result register
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (state_q == S_MUL) begin
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHAMT'(1);
      if (mul_last) begin
        result_d    = mul_sum;
        flags_d     = {mul_sum == '0, mul_sum[BITS-1], 2'b00};
        out_valid_d = 1'b1;
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          result_d    = alu_res;
          flags_d     = alu_flg;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign alu_flags  = flags_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (BITS=64): flags, handshake hold, MUL latency, reset abort.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src_a, src_b;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_result;
  logic [3:0]  alu_flags;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.BITS(64), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    src_a    = a;
    src_b    = b;
    alu_op   = op;
    in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [63:0] res, input logic [3:0] flg);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_res"}, alu_result, res);
    check({tag, "_flags"}, {60'd0, alu_flags}, {60'd0, flg});
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src_a = '0; src_b = '0; alu_op = 4'b0000;
    @(negedge clk);
    step();
    step();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res", alu_result, 64'd0);
    check("rst_flags", {60'd0, alu_flags}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // flags order in the 4-bit field is {Z,N,C,V}
    set_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000); step();
    check_out("add_ovf", 64'h8000_0000_0000_0000, 4'b0101);
    set_op(64'd5, 64'd5, 4'b0001); step();
    check_out("sub_eq", 64'd0, 4'b1010);
    set_op(64'd3, 64'd5, 4'b0001); step();
    check_out("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100);
    set_op(64'h8000_0000_0000_0000, 64'd63, 4'b0111); step();
    check_out("sra63", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
    set_op(64'd1, 64'd64, 4'b0101); step();
    check_out("sll64", 64'd1, 4'b0000);
    set_op(64'hF000_0000_0000_0000, 64'd4, 4'b0110); step();
    check_out("srl4", 64'h0F00_0000_0000_0000, 4'b0000);
    set_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001); step();
    check_out("slt", 64'd1, 4'b0000);
    set_op(64'h1234, 64'h5678, 4'b1111); step();
    check_out("illegal", 64'd0, 4'b0001);

    // back-to-back logic ops, then output stall
    set_op(64'hF0F0, 64'hFF00, 4'b0010); step();
    check_out("and", 64'hF000, 4'b0000);
    set_op(64'hF0F0, 64'hFF00, 4'b0011); step();
    check_out("or", 64'hFFF0, 4'b0000);
    set_op(64'hF0F0, 64'hFF00, 4'b0100); step();
    check_out("xor", 64'h0FF0, 4'b0000);
    set_op(64'd1, 64'd2, 4'b0000);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready0", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("hold", 64'h0FF0, 4'b0000);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check_out("retire_accept", 64'd3, 4'b0000);
    in_valid = 1'b0;
    step();
    check("drain_valid", {63'd0, out_valid}, 64'd0);

    // MUL 3*5 with operands disturbed mid-op
    set_op(64'd3, 64'd5, 4'b1000); step();
    in_valid = 1'b0; src_a = 64'd7; src_b = 64'd9;
    check("mul_busy0", {63'd0, busy}, 64'd1);
    check("mul_in_ready0", {63'd0, in_ready}, 64'd0);
    check("mul_valid0", {63'd0, out_valid}, 64'd0);
    n = 0;
    for (int i = 1; i < 64; i++) begin
      step();
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) n++;
    end
    check("mul_busy_run", n, 64'd0);
    step();
    check("mul_busy_done", {63'd0, busy}, 64'd0);
    check_out("mul_3x5", 64'd15, 4'b0000);

    // MUL latency measured with a bounded wait
    set_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'b1000); step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    check("mul_latency", n, 64'd64);
    check_out("mul_neg", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100);

    // reset at MUL cycle 10 aborts the op
    set_op(64'd6, 64'd7, 4'b1000); step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    step();
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_res", alu_result, 64'd0);
    check("abort_flags", {60'd0, alu_flags}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort_no_result", {63'd0, seen}, 64'd0);

    set_op(64'hABCD, 64'd1, 4'b1010); step();
    in_valid = 1'b0;
    check_out("illegal_1010", 64'd0, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
